message_build_param: RTL and testbench

- Parametrised successor to the SHA-2 message builder. It consumes one configuration word per message (size in bits and scheme), then the message as full DATA_W-bit blocks.
- It emits padded blocks in SHA-2 format: message bits, a single '1' bit, zeros, and a big-endian LEN_W-bit length.
- Compared with the fixed 512/64 builder, it covers SHA-256 (512/64) and SHA-384/512 (1024/128) through parameters, generates the extra padding block itself, and adds a raw passthrough scheme.
- It sits between the input DMA/stream interface and the hash compression engine.

---
 rtl/message_build_param.sv | 131 +++++++++++++
 tb/tb_message_build_param.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_build_param.sv
// SHA-2 message builder: pads the final message block (with an optional extra block)
// for 512/64 or 1024/128 geometries, or passes blocks through unmodified in raw mode.
module message_build_param #(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 64
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_last,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [LEN_W-1:0]  cfg_size,
    input  logic [1:0]        cfg_scheme,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_last,
    output logic              data_out_valid,
    input  logic              data_out_ready
);

    localparam int LB = $clog2(DATA_W);
    localparam int RW = LB + 1;
    localparam logic [RW-1:0]     R_FULL  = RW'(DATA_W);
    localparam logic [RW-1:0]     R_MAX   = RW'(DATA_W - LEN_W - 1);
    localparam logic [DATA_W-1:0] ONES    = '1;
    localparam logic [DATA_W-1:0] TOP_BIT = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DATA, EXTRA} state_t;

    state_t            state_q;
    logic [LEN_W-1:0]  size_q;
    logic              raw_q;
    logic [RW-1:0]     r_q;
    logic [DATA_W-1:0] dout_q;
    logic              last_q;
    logic              valid_q;
    logic              cfg_rdy_q;

    logic              free;
    logic              in_hs;
    logic              cfg_hs;
    logic              fits;
    logic [RW-1:0]     r_d;
    logic [DATA_W-1:0] len_blk;
    logic [DATA_W-1:0] pad_blk;
    logic [DATA_W-1:0] extra_blk;

    always_comb begin
        free   = !valid_q || data_out_ready;
        in_hs  = data_in_valid && data_in_ready;
        cfg_hs = cfg_valid && cfg_rdy_q;
        r_d    = {1'b0, cfg_size[LB-1:0]};
        if (r_d == '0 && cfg_size != '0) begin
            r_d = R_FULL;
        end
        len_blk = '0;
        len_blk[LEN_W-1:0] = size_q;
        fits = (r_q <= R_MAX);
        // Shifting by r == DATA_W clears both terms, so a full final block needs no special case here.
        pad_blk   = (data_in & ~(ONES >> r_q)) | (TOP_BIT >> r_q) | (fits ? len_blk : '0);
        extra_blk = ((r_q == R_FULL) ? TOP_BIT : '0) | len_blk;
    end

    assign data_in_ready  = (state_q == DATA) && free;
    assign cfg_ready      = cfg_rdy_q;
    assign data_out       = dout_q;
    assign data_out_last  = last_q;
    assign data_out_valid = valid_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            size_q    <= '0;
            raw_q     <= 1'b0;
            r_q       <= '0;
            dout_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            cfg_rdy_q <= 1'b0;
        end else begin
            if (valid_q && data_out_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    cfg_rdy_q <= 1'b1;
                    if (cfg_hs) begin
                        size_q    <= cfg_size;
                        raw_q     <= (cfg_scheme == 2'd1);
                        r_q       <= r_d;
                        cfg_rdy_q <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (in_hs) begin
                        valid_q <= 1'b1;
                        if (raw_q || !data_in_last) begin
                            dout_q <= data_in;
                            last_q <= data_in_last;
                        end else begin
                            dout_q <= pad_blk;
                            last_q <= fits;
                        end
                        if (data_in_last) begin
                            if (!raw_q && !fits) begin
                                state_q <= EXTRA;
                            end else begin
                                state_q   <= IDLE;
                                cfg_rdy_q <= 1'b1;
                            end
                        end
                    end
                end
                EXTRA: begin
                    if (free) begin
                        dout_q    <= extra_blk;
                        last_q    <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                        cfg_rdy_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_message_build_param.sv
// Bench for message_build_param: a 512/64 and a 1024/128 instance driven with directed and
// random messages, checked against a bit-level SHA-2 padding model.
module tb_message_build_param;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [1023:0] din;
    logic          din_last;
    logic [1:0]    din_valid, din_rdy;
    logic [127:0]  csize;
    logic [1:0]    cscheme;
    logic [1:0]    cvalid, crdy;
    logic [511:0]  dout_a;
    logic [1023:0] dout_b;
    logic [1:0]    dlast, dvalid, out_rdy;

    int rdy_mode = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1023:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[2][$];
    beat_t         got_q[2][$];
    logic [1023:0] blk_q[$];

    message_build_param #(.DATA_W(512), .LEN_W(64)) u_a (
        .clk(clk), .nrst(nrst),
        .data_in(din[511:0]), .data_in_last(din_last), .data_in_valid(din_valid[0]), .data_in_ready(din_rdy[0]),
        .cfg_size(csize[63:0]), .cfg_scheme(cscheme), .cfg_valid(cvalid[0]), .cfg_ready(crdy[0]),
        .data_out(dout_a), .data_out_last(dlast[0]), .data_out_valid(dvalid[0]), .data_out_ready(out_rdy[0])
    );

    message_build_param #(.DATA_W(1024), .LEN_W(128)) u_b (
        .clk(clk), .nrst(nrst),
        .data_in(din), .data_in_last(din_last), .data_in_valid(din_valid[1]), .data_in_ready(din_rdy[1]),
        .cfg_size(csize), .cfg_scheme(cscheme), .cfg_valid(cvalid[1]), .cfg_ready(crdy[1]),
        .data_out(dout_b), .data_out_last(dlast[1]), .data_out_valid(dvalid[1]), .data_out_ready(out_rdy[1])
    );

    always @(posedge clk) begin
        #2;
        out_rdy = (rdy_mode == 0) ? 2'b11 : (rdy_mode == 1) ? 2'($urandom) : 2'b00;
    end

    always @(negedge clk) begin
        beat_t b;
        if (dvalid[0] && out_rdy[0]) begin
            b.d = {512'b0, dout_a};
            b.l = dlast[0];
            got_q[0].push_back(b);
        end
        if (dvalid[1] && out_rdy[1]) begin
            b.d = dout_b;
            b.l = dlast[1];
            got_q[1].push_back(b);
        end
    end

    // Padded message = bits [0,size) of input, a '1' at bit size, zeros, length in the last LEN_W bits.
    function automatic void model(input int s, input int unsigned size, input int scheme);
        int unsigned dw = (s != 0) ? 1024 : 512;
        int unsigned lw = (s != 0) ? 128 : 64;
        int unsigned total, nout, g, pos;
        logic [31:0] sz;
        logic [1023:0] src;
        beat_t b;
        sz = size;
        if (scheme == 1) begin
            for (int k = 0; k < blk_q.size(); k++) begin
                b.d = blk_q[k];
                b.l = (k == blk_q.size() - 1);
                exp_q[s].push_back(b);
            end
        end else begin
            total = ((size + 1 + lw + dw - 1) / dw) * dw;
            nout  = total / dw;
            for (int unsigned k = 0; k < nout; k++) begin
                b.d = '0;
                src = (k < blk_q.size()) ? blk_q[k] : '0;
                for (int unsigned bb = 0; bb < dw; bb++) begin
                    g = k * dw + dw - 1 - bb;
                    if (g < size) b.d[bb] = src[bb];
                    else if (g == size) b.d[bb] = 1'b1;
                    else if (g >= total - lw) begin
                        pos = total - 1 - g;
                        b.d[bb] = (pos < 32) ? sz[pos] : 1'b0;
                    end
                end
                b.l = (k == nout - 1);
                exp_q[s].push_back(b);
            end
        end
    endfunction

    task automatic gen_blocks(input int s, input int unsigned size);
        int unsigned dw = (s != 0) ? 1024 : 512;
        int unsigned n = (size == 0) ? 1 : (size + dw - 1) / dw;
        logic [1023:0] v;
        blk_q.delete();
        for (int unsigned k = 0; k < n; k++) begin
            for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
            if (s == 0) v[1023:512] = '0;
            blk_q.push_back(v);
        end
    endtask

    task automatic clear_q();
        for (int s = 0; s < 2; s++) begin
            exp_q[s].delete();
            got_q[s].delete();
        end
    endtask

    task automatic send_msg(input int s, input int unsigned size, input int scheme, input int cut);
        bit hs;
        model(s, size, scheme);
        csize   = 128'(size);
        cscheme = 2'(scheme);
        cvalid[s] = 1'b1;
        hs = 0;
        for (int t = 0; t < 300 && !hs; t++) begin
            @(negedge clk);
            hs = crdy[s];
            @(posedge clk); #1;
        end
        cvalid[s] = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL cfg_handshake inst %0d got timeout want cfg_ready", s);
            return;
        end
        for (int k = 0; k < cut && k < blk_q.size(); k++) begin
            din = blk_q[k];
            din_last = (k == blk_q.size() - 1);
            din_valid[s] = 1'b1;
            hs = 0;
            for (int t = 0; t < 300 && !hs; t++) begin
                @(negedge clk);
                hs = din_rdy[s];
                @(posedge clk); #1;
            end
            din_valid[s] = 1'b0;
            checks++;
            if (!hs) begin
                errors++;
                $display("FAIL data_handshake inst %0d beat %0d got timeout want data_in_ready", s, k);
                return;
            end
        end
    endtask

    task automatic drain(input int s, output bit ok);
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            ok = (got_q[s].size() >= exp_q[s].size());
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        din = '0; din_last = 0; din_valid = 0; csize = '0; cscheme = 0; cvalid = 0;
        nrst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (dvalid !== 2'b00 || dlast !== 2'b00 || dout_a !== '0 || dout_b !== '0 || din_rdy !== 2'b00 || crdy !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs got valid %b last %b in_rdy %b cfg_rdy %b want all 0", dvalid, dlast, din_rdy, crdy);
        end
        @(posedge clk); #1;
        nrst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (crdy !== 2'b11) begin
            errors++;
            $display("FAIL reset_cfg_ready got %b want 11", crdy);
        end
    endtask

    task automatic test_abc();
        logic [1023:0] v;
        logic [511:0] want;
        bit ok;
        clear_q();
        v = '0;
        v[511:0] = {24'h616263, {488{1'b1}}};
        blk_q.delete();
        blk_q.push_back(v);
        send_msg(0, 24, 0, 1);
        drain(0, ok);
        want = {24'h616263, 8'h80, 416'b0, 64'd24};
        checks++;
        if (got_q[0].size() != 1) begin
            errors++;
            $display("FAIL abc_count got %0d want 1", got_q[0].size());
        end else begin
            checks++;
            if (got_q[0][0].d[511:0] !== want || got_q[0][0].l !== 1'b1) begin
                errors++;
                $display("FAIL abc_block got %h last %0b want %h last 1", got_q[0][0].d[511:0], got_q[0][0].l, want);
            end
        end
    endtask

    task automatic test_extra448();
        bit ok;
        clear_q();
        gen_blocks(0, 448);
        send_msg(0, 448, 0, 1);
        drain(0, ok);
        checks++;
        if (got_q[0].size() != 2) begin
            errors++;
            $display("FAIL extra448_count got %0d want 2", got_q[0].size());
        end else begin
            checks++;
            if (got_q[0][0].d[511:64] !== blk_q[0][511:64] || got_q[0][0].d[63:0] !== 64'h8000_0000_0000_0000 || got_q[0][0].l !== 1'b0) begin
                errors++;
                $display("FAIL extra448_b1 got low %h last %0b want low 8000000000000000 last 0", got_q[0][0].d[63:0], got_q[0][0].l);
            end
            checks++;
            if (got_q[0][1].d !== 1024'h1C0 || got_q[0][1].l !== 1'b1) begin
                errors++;
                $display("FAIL extra448_b2 got low %h last %0b want 1c0 last 1", got_q[0][1].d[127:0], got_q[0][1].l);
            end
        end
    endtask

    task automatic test_full1024();
        bit ok;
        logic [1023:0] want;
        clear_q();
        gen_blocks(0, 1024);
        send_msg(0, 1024, 0, 2);
        drain(0, ok);
        want = '0;
        want[511] = 1'b1;
        want[63:0] = 64'h400;
        checks++;
        if (got_q[0].size() != 3) begin
            errors++;
            $display("FAIL full_count got %0d want 3", got_q[0].size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got_q[0][k].d !== blk_q[k] || got_q[0][k].l !== 1'b0) begin
                    errors++;
                    $display("FAIL full_data%0d got low %h last %0b want low %h last 0", k, got_q[0][k].d[127:0], got_q[0][k].l, blk_q[k][127:0]);
                end
            end
            checks++;
            if (got_q[0][2].d !== want || got_q[0][2].l !== 1'b1) begin
                errors++;
                $display("FAIL full_extra got top %0b low %h last %0b want top 1 low 400 last 1", got_q[0][2].d[511], got_q[0][2].d[63:0], got_q[0][2].l);
            end
        end
    endtask

    task automatic test_size0_raw();
        bit ok;
        logic [1023:0] want;
        clear_q();
        gen_blocks(0, 0);
        send_msg(0, 0, 0, 1);
        drain(0, ok);
        want = '0;
        want[511] = 1'b1;
        checks++;
        if (got_q[0].size() != 1 || got_q[0][0].d !== want || got_q[0][0].l !== 1'b1) begin
            errors++;
            $display("FAIL size0 got count %0d low %h want count 1 block 800..0 last 1", got_q[0].size(), (got_q[0].size() > 0) ? got_q[0][0].d[511:384] : '0);
        end
        clear_q();
        gen_blocks(0, 1536);
        send_msg(0, 1536, 1, 3);
        drain(0, ok);
        checks++;
        if (got_q[0].size() != 3) begin
            errors++;
            $display("FAIL raw_count got %0d want 3", got_q[0].size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got_q[0][k].d !== blk_q[k] || got_q[0][k].l !== (k == 2)) begin
                    errors++;
                    $display("FAIL raw_beat%0d got low %h last %0b want low %h last %0b", k, got_q[0][k].d[127:0], got_q[0][k].l, blk_q[k][127:0], k == 2);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        beat_t e, g;
        logic [511:0] held;
        logic hl;
        clear_q();
        gen_blocks(0, 1536);
        rdy_mode = 2;
        fork
            send_msg(0, 1536, 1, 3);
            begin
                for (int t = 0; t < 50 && !dvalid[0]; t++) @(negedge clk);
                held = dout_a;
                hl = dlast[0];
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    checks++;
                    if (dout_a !== held || dlast[0] !== hl || dvalid[0] !== 1'b1 || din_rdy[0] !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cyc %0d got valid %0b in_rdy %0b stable %0b want valid 1 in_rdy 0 stable 1", i, dvalid[0], din_rdy[0], dout_a === held);
                    end
                end
                @(posedge clk); #1;
                rdy_mode = 0;
            end
        join
        drain(0, ok);
        checks++;
        if (got_q[0].size() != exp_q[0].size()) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", got_q[0].size(), exp_q[0].size());
        end
        while (exp_q[0].size() > 0 && got_q[0].size() > 0) begin
            e = exp_q[0].pop_front();
            g = got_q[0].pop_front();
            checks++;
            if (g.d !== e.d || g.l !== e.l) begin
                errors++;
                $display("FAIL bp_block got low %h last %0b want low %h last %0b", g.d[127:0], g.l, e.d[127:0], e.l);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        beat_t e, g;
        clear_q();
        rdy_mode = 2;
        gen_blocks(0, 1500);
        send_msg(0, 1500, 0, 1);
        @(negedge clk);
        checks++;
        if (dvalid[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pending got valid %0b want 1", dvalid[0]);
        end
        #2;
        nrst = 0;
        #1;
        checks++;
        if (dvalid[0] !== 1'b0 || dout_a !== '0 || dlast[0] !== 1'b0 || din_rdy[0] !== 1'b0 || crdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got valid %0b last %0b in_rdy %0b cfg_rdy %0b data_zero %0b want all 0", dvalid[0], dlast[0], din_rdy[0], crdy[0], dout_a === '0);
        end
        @(posedge clk); #1;
        nrst = 1;
        rdy_mode = 0;
        clear_q();
        gen_blocks(0, 24);
        blk_q[0][511:488] = 24'h616263;
        send_msg(0, 24, 0, 1);
        drain(0, ok);
        checks++;
        if (got_q[0].size() != 1) begin
            errors++;
            $display("FAIL midrst_count got %0d want 1", got_q[0].size());
        end else begin
            e = exp_q[0].pop_front();
            g = got_q[0].pop_front();
            checks++;
            if (g.d[511:448] !== 64'h6162_6380_0000_0000 || g.d[63:0] !== 64'd24 || g.d !== e.d || g.l !== 1'b1) begin
                errors++;
                $display("FAIL midrst_block got top %h low %h last %0b want top 6162638000000000 low 18 last 1", g.d[511:448], g.d[63:0], g.l);
            end
        end
    endtask

    task automatic test_wide();
        bit ok;
        clear_q();
        gen_blocks(1, 24);
        send_msg(1, 24, 0, 1);
        drain(1, ok);
        checks++;
        if (got_q[1].size() != 1) begin
            errors++;
            $display("FAIL wide24_count got %0d want 1", got_q[1].size());
        end else begin
            checks++;
            if (got_q[1][0].d[1023:1000] !== blk_q[0][1023:1000] || got_q[1][0].d[999] !== 1'b1 || got_q[1][0].d[998:128] !== '0
                || got_q[1][0].d[127:0] !== 128'h18 || got_q[1][0].l !== 1'b1) begin
                errors++;
                $display("FAIL wide24_block got b999 %0b low %h last %0b want b999 1 low 18 last 1", got_q[1][0].d[999], got_q[1][0].d[127:0], got_q[1][0].l);
            end
        end
        clear_q();
        gen_blocks(1, 896);
        send_msg(1, 896, 0, 1);
        drain(1, ok);
        checks++;
        if (got_q[1].size() != 2) begin
            errors++;
            $display("FAIL wide896_count got %0d want 2", got_q[1].size());
        end else begin
            checks++;
            if (got_q[1][0].d[127] !== 1'b1 || got_q[1][0].d[126:0] !== '0 || got_q[1][0].l !== 1'b0
                || got_q[1][1].d !== 1024'h380 || got_q[1][1].l !== 1'b1) begin
                errors++;
                $display("FAIL wide896_blocks got b127 %0b last0 %0b len %h last1 %0b want b127 1 last0 0 len 380 last1 1",
                         got_q[1][0].d[127], got_q[1][0].l, got_q[1][1].d[127:0], got_q[1][1].l);
            end
        end
    endtask

    task automatic test_random();
        int unsigned edge_a[8] = '{0, 1, 447, 448, 449, 511, 512, 513};
        int unsigned edge_b[8] = '{0, 895, 896, 897, 1023, 1024, 1025, 2047};
        int unsigned size, dw;
        int s, scheme;
        bit ok;
        beat_t e, g;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            s = i % 2;
            dw = (s != 0) ? 1024 : 512;
            if (i < 16) size = (s != 0) ? edge_b[i/2] : edge_a[i/2];
            else size = $urandom_range(0, 3 * dw);
            scheme = $urandom_range(0, 3);
            clear_q();
            gen_blocks(s, size);
            send_msg(s, size, scheme, blk_q.size());
            drain(s, ok);
            checks++;
            if (!ok || got_q[s].size() != exp_q[s].size()) begin
                errors++;
                $display("FAIL rand_count inst %0d size %0d scheme %0d got %0d want %0d", s, size, scheme, got_q[s].size(), exp_q[s].size());
            end
            while (exp_q[s].size() > 0 && got_q[s].size() > 0) begin
                e = exp_q[s].pop_front();
                g = got_q[s].pop_front();
                checks++;
                if (g.d !== e.d || g.l !== e.l) begin
                    errors++;
                    $display("FAIL rand_block inst %0d size %0d scheme %0d got low %h last %0b want low %h last %0b",
                             s, size, scheme, g.d[127:0], g.l, e.d[127:0], e.l);
                end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_extra448();
        test_full1024();
        test_size0_raw();
        test_backpressure();
        test_reset_mid();
        test_wide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
